// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks IF/ID/EX/MEM/WB per instruction,
// with halt requests, illegal-opcode and ready-timeout detection, and a retire counter.
module stage_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             instr_ready,
    input  logic             mem_ready,
    input  logic [6:0]       opcode,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_we,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halt_pending_q, halt_pending_d;
    logic              err_d;
    logic [CNT_W-1:0]  count_d;
    logic              legal_op;
    logic              mem_op;
    logic              err_set;
    logic              clear_run;
    logic              retire;

    // State, bookkeeping and Moore-decoded outputs, all registered from next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            wait_q         <= '0;
            halt_pending_q <= 1'b0;
            err            <= 1'b0;
            instr_count    <= '0;
            if_en          <= 1'b0;
            id_en          <= 1'b0;
            ex_en          <= 1'b0;
            mem_en         <= 1'b0;
            wb_en          <= 1'b0;
            pc_we          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            halt_pending_q <= halt_pending_d;
            err            <= err_d;
            instr_count    <= count_d;
            if_en          <= (state_d == S_IF);
            id_en          <= (state_d == S_ID);
            ex_en          <= (state_d == S_EX);
            mem_en         <= (state_d == S_MEM);
            wb_en          <= (state_d == S_WB);
            pc_we          <= (state_d == S_WB);
            busy           <= (state_d != S_IDLE) && (state_d != S_HALT);
            done           <= (state_d == S_HALT);
        end
    end

    assign state = state_q;

    // Next-state and bookkeeping updates
    always_comb begin
        state_d        = state_q;
        err_set        = 1'b0;
        clear_run      = 1'b0;
        retire         = 1'b0;
        legal_op       = 1'b0;
        mem_op         = (opcode == 7'b0000011) || (opcode == 7'b0100011);
        wait_d         = '0;
        halt_pending_d = halt_pending_q;
        err_d          = err;
        count_d        = instr_count;

        case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: legal_op = 1'b1;
            default:                            legal_op = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (halt_req)   state_d = S_HALT;
                else if (start) state_d = S_IF;
            end
            S_IF: begin
                if (instr_ready) begin
                    state_d = S_ID;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end
            end
            S_ID: begin
                if (legal_op) begin
                    state_d = S_EX;
                end else begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end
            end
            S_EX: state_d = mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    err_set = 1'b1;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = halt_pending_q ? S_HALT : S_IF;
            end
            S_HALT: begin
                if (start && !halt_req) begin
                    state_d   = S_IF;
                    clear_run = 1'b1;
                end
            end
            default: begin
                state_d = S_HALT;
                err_set = 1'b1;
            end
        endcase

        // Wait counter restarts on every entry into a ready-wait state
        if (((state_d == S_IF) || (state_d == S_MEM)) && (state_d == state_q))
            wait_d = wait_q + WAIT_W'(1);

        if ((state_d == S_HALT) && (state_q != S_HALT)) halt_pending_d = 1'b0;
        else if (clear_run)                              halt_pending_d = 1'b0;
        else if (halt_req)                               halt_pending_d = 1'b1;

        if (clear_run) err_d = 1'b0;
        else if (err_set) err_d = 1'b1;

        if (clear_run)   count_d = '0;
        else if (retire) count_d = instr_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: hand-computed state walks for ALU, load,
// halt, illegal opcode, timeout, counter wrap and asynchronous reset.
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       halt_req;
    logic       instr_ready;
    logic       mem_ready;
    logic [6:0] opcode;
    logic       if_en, id_en, ex_en, mem_en, wb_en;
    logic       pc_we, busy, done, err;
    logic [2:0] state;
    logic [3:0] instr_count;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    stage_sequencer #(.TIMEOUT(16), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .instr_ready (instr_ready),
        .mem_ready   (mem_ready),
        .opcode      (opcode),
        .if_en       (if_en),
        .id_en       (id_en),
        .ex_en       (ex_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .pc_we       (pc_we),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected enables/busy/done follow from the expected state code
    task automatic check_out(input string tag, input logic [2:0] st, input logic e,
                             input logic [3:0] cnt);
        logic [4:0] en_exp;
        en_exp = 5'b00000;
        if (st >= 3'd1 && st <= 3'd5) en_exp = 5'b10000 >> (st - 3'd1);
        cmp({tag, ".state"}, 32'(state), 32'(st));
        cmp({tag, ".en"}, 32'({if_en, id_en, ex_en, mem_en, wb_en}), 32'(en_exp));
        cmp({tag, ".pc_we"}, 32'(pc_we), 32'(en_exp[0]));
        cmp({tag, ".busy"}, 32'(busy), 32'((st != 3'd0) && (st != 3'd6)));
        cmp({tag, ".done"}, 32'(done), 32'(st == 3'd6));
        cmp({tag, ".err"}, 32'(err), 32'(e));
        cmp({tag, ".count"}, 32'(instr_count), 32'(cnt));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; halt_req = 1'b0;
        instr_ready = 1'b0; mem_ready = 1'b0; opcode = OP_ALU;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 3'd0, 1'b0, 4'd0);
        rst = 1'b1;
        step(); step();
        check_out("idle_hold", 3'd0, 1'b0, 4'd0);

        // ALU instruction: 1,2,3,5 then back to 1
        instr_ready = 1'b1; opcode = OP_ALU; start = 1'b1;
        step(); start = 1'b0;
        check_out("alu_if", 3'd1, 1'b0, 4'd0);
        step(); check_out("alu_id", 3'd2, 1'b0, 4'd0);
        step(); check_out("alu_ex", 3'd3, 1'b0, 4'd0);
        step(); check_out("alu_wb", 3'd5, 1'b0, 4'd0);
        step(); check_out("alu_next", 3'd1, 1'b0, 4'd1);

        // Load with mem_ready low for three MEM cycles
        opcode = OP_LOAD; mem_ready = 1'b0;
        step(); check_out("ld_id", 3'd2, 1'b0, 4'd1);
        step(); check_out("ld_ex", 3'd3, 1'b0, 4'd1);
        step(); check_out("ld_mem1", 3'd4, 1'b0, 4'd1);
        step(); check_out("ld_mem2", 3'd4, 1'b0, 4'd1);
        step(); check_out("ld_mem3", 3'd4, 1'b0, 4'd1);
        step(); check_out("ld_mem4", 3'd4, 1'b0, 4'd1);
        mem_ready = 1'b1;
        step(); check_out("ld_wb", 3'd5, 1'b0, 4'd1);
        mem_ready = 1'b0;
        step(); check_out("ld_next", 3'd1, 1'b0, 4'd2);

        // Halt request during EX lets WB finish
        opcode = OP_ALU;
        step(); check_out("h_id", 3'd2, 1'b0, 4'd2);
        step(); check_out("h_ex", 3'd3, 1'b0, 4'd2);
        halt_req = 1'b1;
        step(); halt_req = 1'b0;
        check_out("h_wb", 3'd5, 1'b0, 4'd2);
        step(); check_out("h_halt", 3'd6, 1'b0, 4'd3);
        step(); step();
        check_out("h_stay", 3'd6, 1'b0, 4'd3);

        // Illegal opcode after one retired instruction
        start = 1'b1;
        step(); start = 1'b0;
        check_out("restart", 3'd1, 1'b0, 4'd0);
        step(); step(); step(); step();
        check_out("ill_pre", 3'd1, 1'b0, 4'd1);
        opcode = OP_BAD;
        step(); check_out("ill_id", 3'd2, 1'b0, 4'd1);
        step(); check_out("ill_halt", 3'd6, 1'b1, 4'd1);
        step(); check_out("ill_stay", 3'd6, 1'b1, 4'd1);
        start = 1'b1; opcode = OP_ALU;
        step(); start = 1'b0;
        check_out("ill_restart", 3'd1, 1'b0, 4'd0);

        // instr_ready low for 16 IF cycles times out
        instr_ready = 1'b0;
        repeat (15) step();
        check_out("to_wait16", 3'd1, 1'b0, 4'd0);
        step(); check_out("to_halt", 3'd6, 1'b1, 4'd0);
        start = 1'b1;
        step(); start = 1'b0;
        check_out("to_restart", 3'd1, 1'b0, 4'd0);
        repeat (15) step();
        instr_ready = 1'b1;
        step(); check_out("to_ready", 3'd2, 1'b0, 4'd0);

        // Retire counter wraps at 16 with CNT_W=4
        step(); step(); step();
        check_out("wrap1", 3'd1, 1'b0, 4'd1);
        repeat (56) step();
        check_out("wrap15", 3'd1, 1'b0, 4'd15);
        repeat (4) step();
        check_out("wrap0", 3'd1, 1'b0, 4'd0);

        // Asynchronous reset in MEM
        repeat (4) step();
        check_out("pre_ld", 3'd1, 1'b0, 4'd1);
        opcode = OP_LOAD; mem_ready = 1'b0;
        step(); step(); step();
        check_out("rst_mem", 3'd4, 1'b0, 4'd1);
        #2 rst = 1'b0;
        #1 check_out("rst_async", 3'd0, 1'b0, 4'd0);
        step(); check_out("rst_hold", 3'd0, 1'b0, 4'd0);
        rst = 1'b1;
        step(); check_out("rst_idle", 3'd0, 1'b0, 4'd0);

        // halt_req beats start in IDLE and holds HALT
        halt_req = 1'b1; start = 1'b1;
        step(); check_out("idle_halt", 3'd6, 1'b0, 4'd0);
        step(); check_out("halt_both", 3'd6, 1'b0, 4'd0);
        halt_req = 1'b0;
        step(); start = 1'b0;
        check_out("halt_start", 3'd1, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: maximum wait cycles in IF or MEM before a timeout error.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin execution from IDLE or HALT.
REQ-007 halt_req  input  1  request a stop at the next instruction boundary.
REQ-008 instr_ready  input  1  instruction memory has IR valid.
REQ-009 mem_ready  input  1  data access complete.
REQ-010 opcode  input  7  IF_ID_IR[6:0] of the current instruction.
REQ-011 if_en, id_en, ex_en, mem_en, wb_en  output  1 each  stage enables.
REQ-012 pc_we  output  1  PC register load of PC_NEXT.
REQ-013 busy  output  1  high in any state except IDLE and HALT.
REQ-014 done  output  1  high in HALT.
REQ-015 err  output  1  sticky illegal-opcode or timeout flag.
REQ-016 state  output  3  encoded current state.
REQ-017 instr_count  output  CNT_W  count of retired instructions.

Function
REQ-018 States SHALL be encoded IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6; code 7 SHALL go to HALT with err=1.
REQ-019 Stage enables SHALL be Moore-decoded from state: exactly one of if_en..wb_en is high in states IF..WB, and none are high otherwise.
REQ-020 pc_we SHALL equal wb_en.
REQ-021 IDLE: start=1 -> IF; otherwise the FSM stays in IDLE.
REQ-022 IF: instr_ready=1 -> ID; otherwise the FSM stays in IF.
REQ-023 ID: if opcode is one of the RV32I major opcodes {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}, the next state SHALL be EX; otherwise the next state SHALL be HALT and err SHALL be set.
REQ-024 EX: opcode 0000011 (load) or 0100011 (store) -> MEM; any other opcode -> WB. EX SHALL always last exactly 1 cycle.
REQ-025 MEM: mem_ready=1 -> WB; otherwise the FSM stays in MEM.
REQ-026 WB: the FSM SHALL stay in WB for 1 cycle and instr_count SHALL increment by 1, wrapping modulo 2^CNT_W. If halt_pending=1 the next state SHALL be HALT; otherwise it SHALL be IF.
REQ-027 halt_pending SHALL set on halt_req=1 in any cycle and SHALL clear on entry to HALT; an instruction already in flight SHALL always complete through WB.
REQ-028 halt_req=1 in IDLE SHALL move the FSM to HALT on the next cycle; halt_req has priority over start in IDLE.
REQ-029 A wait counter SHALL reset on entry to IF and to MEM and increment each cycle spent waiting. When it reaches TIMEOUT-1 with ready still low, the next state SHALL be HALT and err SHALL set; ready arriving in that same cycle SHALL win.
REQ-030 HALT: start=1 -> IF, clearing err, halt_pending and instr_count. If halt_req and start are both high in HALT, the FSM SHALL stay in HALT.
REQ-031 Latency: non-memory instruction SHALL take 4 cycles with instr_ready already high; load/store SHALL take 5 cycles plus mem_ready wait.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, all enables=0, pc_we=0, busy=0, done=0, err=0, instr_count=0, halt_pending=0, wait counter=0, regardless of clk.
REQ-033 Reset asserted mid-instruction SHALL abandon the instruction with no WB pulse; instr_count SHALL NOT increment.
REQ-034 After rst deasserts, the FSM SHALL remain in IDLE until start.

Verification
REQ-035 start pulse, instr_ready=1, opcode=0110011 -> state sequence 1,2,3,5,1 over 4 cycles; a 1-cycle pc_we pulse in WB; instr_count=1.
REQ-036 opcode=0000011, mem_ready low 3 cycles -> MEM held 4 cycles, then WB; total instruction time 8 cycles.
REQ-037 halt_req pulse during EX of an ALU instruction -> WB completes, instr_count increments, then HALT with done=1 and no further if_en.
REQ-038 opcode=1111111 in ID -> next state HALT, err=1, no WB, instr_count unchanged; start then -> IF with err=0 and instr_count=0.
REQ-039 instr_ready held low 16 cycles (TIMEOUT=16) -> HALT with err=1; repeat with ready arriving on the 16th cycle -> ID, err=0.
REQ-040 rst low asynchronously during MEM -> outputs reach reset values before the next clk edge; CNT_W=4 with 16 retired instructions -> instr_count wraps to 0.
